shift_add_multiplier: RTL

- Sequential 8x8 multiplier controller sitting directly upstream of the 8-bit arithmetic unit.
- Drives that unit's select/carry-in/operand inputs each cycle and consumes its sum, carry and overflow outputs.
- Produces a 16-bit product via iterative shift-add (unsigned) or radix-2 Booth (signed, optional).
- The arithmetic unit is instantiated beside this block in the parent, not inside it.

---
 rtl/mul_pkg.sv | 17 +
 rtl/shift_add_multiplier.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the shift-add / Booth multiplier controller.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] ARITH_PASS = 2'b00;
  localparam logic [1:0] ARITH_ADD  = 2'b01;
  localparam logic [1:0] ARITH_SUB  = 2'b10;

  localparam int MUL_WIDTH = 8;
  localparam int MUL_ITER  = 8;

endpackage

// File: rtl/shift_add_multiplier.sv
// Sequential 8x8 multiplier driving an external 8-bit arithmetic unit.
// Define SIGNED_BOOTH_MUL_EN for signed radix-2 Booth; default is unsigned shift-add.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [1:0]         arith_s,
  output logic               arith_cin,
  output logic [WIDTH-1:0]   arith_a,
  output logic [WIDTH-1:0]   arith_b,
  input  logic [WIDTH-1:0]   arith_out,
  input  logic               arith_c,
  input  logic               arith_v,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               q_m1_q, q_m1_d;
  logic               shift_in;

  // Op select depends only on registered state, so the external unit's
  // combinational return path never loops back into the select.
  always_comb begin
    arith_s   = ARITH_PASS;
    arith_cin = 1'b0;
    if (state_q == RUN) begin
`ifdef SIGNED_BOOTH_MUL_EN
      case ({q_q[0], q_m1_q})
        2'b01: begin
          arith_s   = ARITH_ADD;
          arith_cin = 1'b0;
        end
        2'b10: begin
          arith_s   = ARITH_SUB;
          arith_cin = 1'b1;
        end
        default: begin
          arith_s   = ARITH_PASS;
          arith_cin = 1'b0;
        end
      endcase
`else
      if (q_q[0]) arith_s = ARITH_ADD;
`endif
    end
  end

`ifdef SIGNED_BOOTH_MUL_EN
  // True sign of the 9-bit result, correct even when M = -128 overflows.
  assign shift_in = arith_out[WIDTH-1] ^ arith_v;
  logic unused_c;
  assign unused_c = arith_c;
`else
  assign shift_in = (arith_s == ARITH_ADD) ? arith_c : 1'b0;
  logic unused_v;
  assign unused_v = arith_v ^ q_m1_q;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_d     = q_q;
    m_d     = m_q;
    count_d = count_q;
    q_m1_d  = q_m1_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          acc_d   = '0;
          q_m1_d  = 1'b0;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = {shift_in, arith_out[WIDTH-1:1]};
        q_d     = {arith_out[0], q_q[WIDTH-1:1]};
`ifdef SIGNED_BOOTH_MUL_EN
        q_m1_d  = q_q[0];
`endif
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(MUL_ITER - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      count_q <= '0;
      q_m1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      m_q     <= m_d;
      count_q <= count_d;
      q_m1_q  <= q_m1_d;
    end
  end

  assign arith_a = acc_q;
  assign arith_b = m_q;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = {acc_q, q_q};

endmodule
